// File: rtl/cdu_pkg.sv
// Shared types and field positions for the CDU read-counter sequencer.
package cdu_pkg;
   localparam int RC_W    = 16;
   localparam int FLD_LSB = 10;
   localparam int FLD_W   = 6;
   // positions inside the rc[15:10] decode field
   localparam int Q_POS   = 4;
   localparam int S_POS   = 2;
   localparam int H_POS   = 1;
   localparam int B_POS   = 0;

   typedef enum logic {RUN = 1'b0, BBM = 1'b1} cdu_state_t;

   // bit n-1 drives _Dn; 0 = switch closed
   typedef logic [13:0] cdu_sw_t;

   localparam cdu_sw_t SW_OPEN  = 14'h3FFF;
   localparam cdu_sw_t SW_RESET = 14'h33FE;
endpackage

// File: rtl/read_counter_decode.sv
// Combinational decode of the read-counter field rc[15:10] into the switch vector.
module read_counter_decode
   import cdu_pkg::*;
(
   input  logic [FLD_W-1:0] fld,
   output cdu_sw_t          sw
);

   logic [1:0] q;
   logic [1:0] s;
   logic [1:0] k;
   logic       h;
   logic       b;

   assign q = fld[Q_POS +: 2];
   assign s = fld[S_POS +: 2];
   assign h = fld[H_POS];
   assign b = fld[B_POS];
   // odd quadrants walk the sectors in reverse
   assign k = q[0] ? (2'd3 - s) : s;

   always_comb begin
      sw     = SW_OPEN;
      sw[k]  = 1'b0;
      sw[4]  = ~q[1];
      sw[6]  = ~(q[1] ^ q[0]);
      sw[10] = h;
      sw[13] = ~h;
      if (h) begin
         sw[8]  = b;
         sw[9]  = ~b;
      end else begin
         sw[11] = b;
         sw[12] = ~b;
      end
   end

endmodule

// File: rtl/read_counter_sequencer.sv
// CDU read counter: rate-selected up/down stepping, switch decode, AGC pulses.
// Break-before-make on sector changes is built only when CDU_BBM_EN is defined.
module read_counter_sequencer
   import cdu_pkg::*;
#(
   parameter int HI_DIV  = 4,
   parameter int LO_DIV  = 32,
   parameter int BBM_CYC = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            err_hi_p,
   input  logic            err_hi_n,
   input  logic            err_lo_p,
   input  logic            err_lo_n,
   input  logic            zero_cdu,
   output logic [RC_W-1:0] rc,
   output logic            cdu_pos,
   output logic            cdu_neg,
   output logic            _D1,
   output logic            _D2,
   output logic            _D3,
   output logic            _D4,
   output logic            _D5,
   output logic            _D6,
   output logic            _D7,
   output logic            _D8,
   output logic            _D9,
   output logic            _D10,
   output logic            _D11,
   output logic            _D12,
   output logic            _D13,
   output logic            _D14,
   output logic            busy
);

   // state | meaning
   // RUN   | steps allowed, switches follow the applied decode
   // BBM   | all switches open, steps inhibited, count down to re-apply

`ifdef CDU_BBM_EN
   localparam bit BBM_ON = 1'b1;
`else
   localparam bit BBM_ON = 1'b0;
`endif

   localparam int PRE_W = $clog2(LO_DIV);
   localparam int HI_W  = $clog2(HI_DIV);
   localparam int CNT_W = $clog2(BBM_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BBM_CYC - 1);

   logic [PRE_W-1:0] pre;
   logic             tick_hi;
   logic             tick_lo;
   logic             up;
   logic             dn;
   logic             step_up;
   logic             step_dn;
   logic [RC_W-1:0]  rc_nxt;
   logic [FLD_W-1:0] fld_q;
   logic [FLD_W-1:0] fld_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   cdu_state_t       state;
   cdu_state_t       state_nxt;
   cdu_sw_t          sw_q;
   cdu_sw_t          sw_nxt;
   cdu_sw_t          dec_sw;
   logic             busy_nxt;

   assign tick_lo = (pre == PRE_W'(LO_DIV - 1));
   assign tick_hi = &pre[HI_W-1:0];

   // a single asserted hi comparator wins; anything else falls to the lo pair
   always_comb begin
      up = 1'b0;
      dn = 1'b0;
      if (tick_hi && (err_hi_p ^ err_hi_n)) begin
         up = err_hi_p;
         dn = err_hi_n;
      end else if (tick_lo && (err_lo_p ^ err_lo_n)) begin
         up = err_lo_p;
         dn = err_lo_n;
      end
   end

   assign step_up = up & (state == RUN) & ~zero_cdu;
   assign step_dn = dn & (state == RUN) & ~zero_cdu;

   always_comb begin
      rc_nxt = rc;
      if (zero_cdu)     rc_nxt = '0;
      else if (step_up) rc_nxt = rc + RC_W'(1);
      else if (step_dn) rc_nxt = rc - RC_W'(1);
   end

   read_counter_decode u_decode (
      .fld (rc_nxt[FLD_LSB +: FLD_W]),
      .sw  (dec_sw)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         cnt     <= '0;
         pre     <= '0;
         rc      <= '0;
         fld_q   <= '0;
         sw_q    <= SW_RESET;
         cdu_pos <= 1'b0;
         cdu_neg <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         pre     <= pre + PRE_W'(1);
         rc      <= rc_nxt;
         fld_q   <= fld_nxt;
         sw_q    <= sw_nxt;
         cdu_pos <= step_up;
         cdu_neg <= step_dn;
         busy    <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         RUN: begin
            if (BBM_ON && (rc_nxt[FLD_LSB +: FLD_W] != fld_q)) begin
               state_nxt = BBM;
               cnt_nxt   = CNT_LOAD;
            end
         end
         BBM: begin
            if (zero_cdu)         cnt_nxt   = CNT_LOAD;
            else if (cnt == '0)   state_nxt = RUN;
            else                  cnt_nxt   = cnt - CNT_W'(1);
         end
         default: state_nxt = RUN;
      endcase
   end

   // in BBM rc cannot move, so the decode of rc_nxt is the current rc on exit
   always_comb begin
      busy_nxt = (state_nxt == BBM);
      fld_nxt  = fld_q;
      sw_nxt   = SW_OPEN;
      if (state_nxt == RUN) begin
         fld_nxt = rc_nxt[FLD_LSB +: FLD_W];
         sw_nxt  = dec_sw;
      end
   end

   assign {_D14, _D13, _D12, _D11, _D10, _D9, _D8,
           _D7, _D6, _D5, _D4, _D3, _D2, _D1} = sw_q;

endmodule
